// File: rtl/tmip_result_deser.sv
// tmip_result_deser: rebuilds MSB-first serial result words from the
// template-matching core, buffers them in a small FIFO and presents them on a
// valid/ready interface. Partial words are flagged with frag_err and words
// that find the FIFO full are dropped and flagged with the sticky ovf.
// Optional frame tagging (word_idx, frame_len latch, per-entry last bit and
// m_last) is compiled in when the macro TMIP_DESER_LAST_EN is defined.
module tmip_result_deser #(
    parameter int WORD_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_bit,
    input  logic [8:0]        frame_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              frag_err,
    output logic              ovf
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_data_q, m_data_d;
    logic              frag_err_q, frag_err_d;
    logic              ovf_q, ovf_d;

    logic              word_done;
    logic              push;
    logic              pop;
    logic              head_is_new;
    logic [WORD_W-1:0] word_new;

    // The word being completed this cycle: shifted history plus the live bit.
    assign word_new = {shreg_q[WORD_W-2:0], s_bit};

    // Serial capture FSM: shift bits in, detect word completion and fragments.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        word_done  = 1'b0;
        frag_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    shreg_d   = word_new;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (s_valid) begin
                    shreg_d = word_new;
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // bit_cnt_q==0 here means the previous word ended cleanly
                    // and the stream simply paused: no fragment to report.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (bit_cnt_q != '0) begin
                        frag_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

`ifdef TMIP_DESER_LAST_EN
    logic [8:0]       word_idx_q, word_idx_d;
    logic [8:0]       flen_q, flen_d;
    logic [DEPTH-1:0] last_mem_q;
    logic             m_last_q, m_last_d;
    logic [9:0]       flen_eff;
    logic             idx_last;

    // Frame tracking: latch frame_len at the first bit of a frame and count
    // completed words (dropped ones included) to tag the last word.
    always_comb begin
        flen_d = flen_q;
        if (s_valid && (bit_cnt_q == '0) && (word_idx_q == 9'd0)) begin
            flen_d = frame_len;
        end
        flen_eff   = (flen_q == 9'd0) ? 10'd512 : {1'b0, flen_q};
        idx_last   = ({1'b0, word_idx_q} == (flen_eff - 10'd1));
        word_idx_d = word_idx_q;
        if (word_done) begin
            word_idx_d = idx_last ? 9'd0 : (word_idx_q + 9'd1);
        end
    end
`else
    logic unused_frame_len;
    assign unused_frame_len = ^frame_len;
`endif

    // FIFO bookkeeping and registered head: next head is computed from the
    // post-update read pointer so m_valid/m_data never depend on m_ready
    // combinationally.
    always_comb begin
        pop  = m_valid_q & m_ready;
        push = word_done & ((count_q < FULL_CNT) | pop);

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q | (word_done & ~push);

        // The incoming word becomes the head only when it lands at the slot
        // the read pointer will point to (FIFO empty, or last entry popped).
        head_is_new = push && (wr_ptr_q == rd_ptr_d);
        m_valid_d   = (count_d != '0);
        m_data_d    = m_data_q;
        if (head_is_new) begin
            m_data_d = word_new;
        end else if (count_d != '0) begin
            m_data_d = mem_q[rd_ptr_d];
        end
`ifdef TMIP_DESER_LAST_EN
        m_last_d = m_last_q;
        if (head_is_new) begin
            m_last_d = idx_last;
        end else if (count_d != '0) begin
            m_last_d = last_mem_q[rd_ptr_d];
        end
`endif
    end

    // Control state and registered outputs, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            frag_err_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef TMIP_DESER_LAST_EN
            word_idx_q <= '0;
            flen_q     <= '0;
            m_last_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            frag_err_q <= frag_err_d;
            ovf_q      <= ovf_d;
`ifdef TMIP_DESER_LAST_EN
            word_idx_q <= word_idx_d;
            flen_q     <= flen_d;
            m_last_q   <= m_last_d;
`endif
        end
    end

    // Datapath storage: shift register and FIFO entries need no reset since
    // bit_cnt and count gate every use of them.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        if (push) begin
            mem_q[wr_ptr_q] <= word_new;
`ifdef TMIP_DESER_LAST_EN
            last_mem_q[wr_ptr_q] <= idx_last;
`endif
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign frag_err = frag_err_q;
    assign ovf      = ovf_q;
`ifdef TMIP_DESER_LAST_EN
    assign m_last   = m_last_q;
`else
    assign m_last   = 1'b0;
`endif

endmodule

// File: tb/tb_tmip_result_deser.sv
// Directed bench for tmip_result_deser (WORD_W=20, DEPTH=4) with a
// scoreboard queue of expected {last, data} entries checked on every pop.
module tb_tmip_result_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_bit;
    logic [8:0]  frame_len;
    logic        m_valid;
    logic        m_ready;
    logic [19:0] m_data;
    logic        m_last;
    logic        frag_err;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    int widx  = 0;
    logic [20:0] sb [$];

    tmip_result_deser #(.WORD_W(20), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_bit     (s_bit),
        .frame_len (frame_len),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frag_err  (frag_err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        widx = 0;
    endtask

    // Queue the expectation (if the word survives), advance the frame
    // position, then drive the 20 bits MSB first.
    task automatic send_word(input logic [19:0] w, input bit keep, input bit rdy_last);
        logic lst;
`ifdef TMIP_DESER_LAST_EN
        lst = (widx == 3);
`else
        lst = 1'b0;
`endif
        widx = (widx == 3) ? 0 : widx + 1;
        if (keep) sb.push_back({lst, w});
        for (int i = 19; i >= 0; i--) begin
            if (i == 0 && rdy_last) m_ready = 1'b1;
            s_valid = 1'b1;
            s_bit   = w[i];
            step();
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard: every accepted head word must match the oldest expectation.
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {12'h0, m_data}, 32'hFFFFFFFF);
            end else begin
                e = sb.pop_front();
                check("pop_data", {12'h0, m_data}, {12'h0, e[19:0]});
                check("pop_last", {31'h0, m_last}, {31'h0, e[20]});
            end
        end
    end

    initial begin
        m_ready   = 1'b0;
        frame_len = 9'd4;
        do_reset();

        // Reset state
        check("rst_m_valid", {31'h0, m_valid}, 32'h0);
        check("rst_m_data", {12'h0, m_data}, 32'h0);
        check("rst_frag", {31'h0, frag_err}, 32'h0);
        check("rst_ovf", {31'h0, ovf}, 32'h0);

        // Single word: visible one cycle after the last bit, popped next cycle
        m_ready = 1'b1;
        send_word(20'hA5A5C, 1'b1, 1'b0);
        check("single_valid", {31'h0, m_valid}, 32'h1);
        check("single_data", {12'h0, m_data}, 32'hA5A5C);
        idle(1);
        check("single_popped", {31'h0, m_valid}, 32'h0);
        check("single_sb_empty", sb.size(), 0);

        // Fragment: 7 bits then a gap, then a clean word
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_bit   = i[0];
            step();
        end
        check("frag_quiet", {31'h0, frag_err}, 32'h0);
        idle(1);
        check("frag_pulse", {31'h0, frag_err}, 32'h1);
        idle(1);
        check("frag_one_cycle", {31'h0, frag_err}, 32'h0);
        send_word(20'h00001, 1'b1, 1'b0);
        idle(3);
        check("frag_no_pulse2", {31'h0, frag_err}, 32'h0);
        check("frag_ovf", {31'h0, ovf}, 32'h0);
        check("frag_sb_empty", sb.size(), 0);

        // Overflow: six words into a 4-deep FIFO with no consumer
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(20'(k), 1'b1, 1'b0);
        check("ovf_before", {31'h0, ovf}, 32'h0);
        send_word(20'd5, 1'b0, 1'b0);
        check("ovf_set", {31'h0, ovf}, 32'h1);
        send_word(20'd6, 1'b0, 1'b0);
        idle(1);
        m_ready = 1'b1;
        idle(8);
        check("ovf_sticky", {31'h0, ovf}, 32'h1);
        check("ovf_drained", {31'h0, m_valid}, 32'h0);
        check("ovf_sb_empty", sb.size(), 0);

        // Full FIFO with a pop on the completion edge of word 5: no drop
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(20'(k), 1'b1, 1'b0);
        send_word(20'd5, 1'b1, 1'b1);
        check("fullpop_ovf", {31'h0, ovf}, 32'h0);
        idle(8);
        check("fullpop_ovf_after", {31'h0, ovf}, 32'h0);
        check("fullpop_sb_empty", sb.size(), 0);

        // Frames of four words: last tags checked through the scoreboard
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) send_word(20'h10 + 20'(k), 1'b1, 1'b0);
        idle(3);
        check("frame_sb_empty", sb.size(), 0);

        // Reset mid-stream with two words buffered and a partial word
        do_reset();
        m_ready = 1'b0;
        send_word(20'h12345, 1'b0, 1'b0);
        send_word(20'h54321, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_bit   = 1'b1;
            step();
        end
        check("mid_valid_before", {31'h0, m_valid}, 32'h1);
        rst     = 1'b1;
        s_valid = 1'b0;
        step();
        check("mid_rst_valid", {31'h0, m_valid}, 32'h0);
        check("mid_rst_data", {12'h0, m_data}, 32'h0);
        check("mid_rst_last", {31'h0, m_last}, 32'h0);
        check("mid_rst_frag", {31'h0, frag_err}, 32'h0);
        check("mid_rst_ovf", {31'h0, ovf}, 32'h0);
        rst = 1'b0;
        sb.delete();
        widx = 0;
        m_ready = 1'b1;
        send_word(20'hFFFFF, 1'b1, 1'b0);
        check("mid_new_data", {12'h0, m_data}, 32'hFFFFF);
        check("mid_new_last", {31'h0, m_last}, 32'h0);
        idle(3);
        check("mid_sb_empty", sb.size(), 0);
        check("mid_frag", {31'h0, frag_err}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
